// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two masters, the RAM and mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the masters/RAM side.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic [1:0]    cpu_cmd;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [1:0]    dma_cmd;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_lock;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [AW-1:0] ram_addr;
  logic          ram_write;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] rdata;
  logic          cmd_err;

  modport slave (
    input  cpu_cmd, cpu_addr, cpu_wdata,
    input  dma_cmd, dma_addr, dma_wdata, dma_lock,
    input  ram_dout,
    output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    output ram_addr, ram_write, ram_din, rdata, cmd_err
  );

  modport master (
    output cpu_cmd, cpu_addr, cpu_wdata,
    output dma_cmd, dma_addr, dma_wdata, dma_lock,
    output ram_dout,
    input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
    input  ram_addr, ram_write, ram_din, rdata, cmd_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM between the CPU and a DMA/loader port.
// DMA may hold the bus for up to MAX_BURST locked grants while the CPU waits.
//
//   state  | meaning
//   S_IDLE | no access granted last cycle
//   S_CPU  | CPU owned the RAM last cycle
//   S_DMA  | DMA owned the RAM last cycle
module mem_port_arbiter #(
  parameter int AW        = 9,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] MREAD   = 2'b01;
  localparam logic [1:0] MWRITE  = 2'b10;
  localparam logic [1:0] MILL    = 2'b11;
  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_DMA = 1'b1;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA} state_t;

  state_t        state;
  logic          last_owner;
  logic [3:0]    burst_cnt;
  logic          rd_pending;
  logic          rd_owner;
  logic          cmd_err_q;

  logic          cpu_req, dma_req, dma_hold;
  logic          cpu_gnt, dma_gnt;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] din_sel;

  assign cpu_req  = (bus.cpu_cmd == MREAD) || (bus.cpu_cmd == MWRITE);
  assign dma_req  = (bus.dma_cmd == MREAD) || (bus.dma_cmd == MWRITE);
  assign dma_hold = (state == S_DMA) && bus.dma_lock && (burst_cnt < BURST_MAX);

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (cpu_req && !dma_req) begin
      cpu_gnt = 1'b1;
    end else if (dma_req && !cpu_req) begin
      dma_gnt = 1'b1;
    end else if (cpu_req && dma_req) begin
      if (dma_hold || (last_owner == OWN_CPU)) dma_gnt = 1'b1;
      else                                     cpu_gnt = 1'b1;
    end
  end

  // Idle cycles park the RAM address/data on the CPU side.
  assign addr_sel = dma_gnt ? bus.dma_addr  : bus.cpu_addr;
  assign din_sel  = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_owner <= OWN_DMA;
      burst_cnt  <= 4'd0;
      rd_pending <= 1'b0;
      rd_owner   <= OWN_CPU;
      cmd_err_q  <= 1'b0;
    end else begin
      if (cpu_gnt)      state <= S_CPU;
      else if (dma_gnt) state <= S_DMA;
      else              state <= S_IDLE;

      if (cpu_gnt)      last_owner <= OWN_CPU;
      else if (dma_gnt) last_owner <= OWN_DMA;

      if (dma_gnt && bus.dma_lock) begin
        if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd0;
      end

      rd_pending <= (cpu_gnt && bus.cpu_cmd == MREAD) || (dma_gnt && bus.dma_cmd == MREAD);
      rd_owner   <= dma_gnt ? OWN_DMA : OWN_CPU;

      if (bus.cpu_cmd == MILL || bus.dma_cmd == MILL) cmd_err_q <= 1'b1;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.ram_addr   = addr_sel;
  assign bus.ram_din    = din_sel;
  assign bus.ram_write  = (cpu_gnt && bus.cpu_cmd == MWRITE) || (dma_gnt && bus.dma_cmd == MWRITE);
  assign bus.cpu_rvalid = rd_pending && (rd_owner == OWN_CPU);
  assign bus.dma_rvalid = rd_pending && (rd_owner == OWN_DMA);
  assign bus.rdata      = bus.ram_dout;
  assign bus.cmd_err    = cmd_err_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous-read RAM between two masters: the CPU (mem_cmd/mem_addr/out) and a DMA/debug loader port.
- Sits between the cpu top level and the RAM. It grants at most one access per cycle, drives the RAM address, write enable and write data, and returns per-master read-valid strobes.
- Arbitration is round-robin with a bounded DMA burst lock, so the CPU is never starved.

Parameters:
- AW, 9, address width (matches mem_addr).
- DW, 16, data width.
- MAX_BURST, 4, maximum consecutive DMA grants under lock while CPU is pending; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- cpu_cmd  in  2  00 = MNONE, 01 = MREAD, 10 = MWRITE, 11 = illegal.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  CPU access taken this cycle (combinational).
- cpu_rvalid  out  1  rdata holds the CPU read result this cycle.
- dma_cmd  in  2  same encoding as cpu_cmd.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_lock  in  1  DMA requests that consecutive grants be kept.
- dma_gnt  out  1  DMA access taken this cycle (combinational).
- dma_rvalid  out  1  rdata holds the DMA read result this cycle.
- ram_addr  out  AW  RAM address.
- ram_write  out  1  RAM write enable.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data; valid one cycle after the read address is applied.
- rdata  out  DW  ram_dout passed straight through to both masters.
- cmd_err  out  1  sticky: an illegal command was seen.

Behaviour:
- Request: a master requests when its cmd is 01 or 10. Cmd 11 is not a request; it sets cmd_err on the next edge, and cmd_err is cleared only by reset.
- States (registered, "owner last cycle"): S_IDLE, S_CPU, S_DMA. Next state is S_CPU if cpu_gnt, S_DMA if dma_gnt, else S_IDLE.
- last_owner register: 1 bit, holds CPU or DMA, updated on every grant, unchanged while idle.
- burst_cnt register: 4 bits.
  - Increments, saturating at MAX_BURST, on a dma_gnt cycle with dma_lock=1.
  - Cleared on any cycle without dma_gnt, and on a dma_gnt cycle with dma_lock=0.
- Grant decision (combinational, same cycle):
  - Only one master requesting: that master is granted.
  - Both requesting, state==S_DMA, dma_lock=1 and burst_cnt<MAX_BURST: DMA is granted.
  - Both requesting, otherwise: the master that is not last_owner is granted (round-robin).
  - cpu_gnt and dma_gnt are never both 1.
- RAM drive:
  - ram_addr, ram_din and ram_write follow the granted master's addr, wdata and cmd==10.
  - With no grant, ram_write=0 and ram_addr/ram_din hold the CPU values.
- Read latency: a read granted in cycle t gives the matching *_rvalid=1 in cycle t+1 only, with rdata=ram_dout. This comes from a registered rd_owner/rd_pending pair, so back-to-back reads from either master pipeline fully.
- Writes: complete in the grant cycle; no rvalid is produced.
- Ungranted master: must hold its cmd/addr/wdata until it is granted. The arbiter keeps no queue.
- Reset values: state=S_IDLE, last_owner=DMA (the first tie goes to CPU), burst_cnt=0, rd_pending=0, cmd_err=0.
- Reset output values: cpu_rvalid=0, dma_rvalid=0, ram_write=0 (with no requests present).
- Reset mid-read: the pending rvalid is dropped and is not reissued after reset.
- Simultaneous events:
  - A grant and an illegal cmd from the other master in the same cycle: the grant proceeds and cmd_err sets.
  - dma_lock falling on a granted cycle: the counter clears that edge.
- MAX_BURST saturation: when the limit is reached with CPU pending, the CPU gets the next grant. DMA can then regain the bus on the following tie via round-robin.

Test Plan:
- Reset, then CPU alone: MREAD to addr 0x005 with ram_dout=0x1234 -> cpu_gnt=1 in cycle t, cpu_rvalid=1 and rdata=0x1234 in t+1, dma_rvalid=0 throughout.
- Tie after reset: both MREAD (cpu 0x010, dma 0x020), dma_lock=0 -> grants alternate CPU, DMA, CPU, DMA; ram_addr sequence 0x010, 0x020, 0x010, 0x020; rvalids alternate one cycle later.
- Burst lock: DMA wins a tie and keeps dma_lock=1 with CPU continuously requesting, MAX_BURST=4 -> exactly 4 consecutive dma_gnt, then cpu_gnt=1 on the 5th cycle; burst_cnt reads 0 after the CPU grant.
- Write path: DMA MWRITE addr 0x1FF data 0xBEEF, CPU idle -> ram_write=1, ram_addr=0x1FF, ram_din=0xBEEF for one cycle, no rvalid; a CPU read of 0x1FF next cycle returns 0xBEEF.
- Illegal and reset: cpu_cmd=11 for one cycle -> no cpu_gnt, cmd_err=1 from the next edge and sticky. Assert reset asynchronously mid-cycle during a pending DMA read -> cmd_err, dma_rvalid and state clear immediately, and no rvalid appears after release.
